// File: rtl/vga_output_stage_pkg.sv
// Shared constants for the VGA output stage: counter widths, sync pin polarity, TMS9918 palette.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vga_output_stage_pkg;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;

    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
    localparam logic [VCNT_W-1:0] VCNT_MAX = '1;

    // Syncs arrive active high and leave on the pins active low, so the idle pin level is 1.
    localparam logic SYNC_PIN_IDLE = 1'b1;

    // TMS9918 palette as 12-bit 0xRGB. Index 0 is "transparent" and is shown as black.
    localparam logic [11:0] PALETTE [16] = '{
        12'h000, 12'h000, 12'h2C3, 12'h5D6,
        12'h54F, 12'h76F, 12'hD54, 12'h4EF,
        12'hF54, 12'hF76, 12'hDC3, 12'hDD8,
        12'h3B2, 12'hC5C, 12'hCCC, 12'hFFF
    };

endpackage

// File: rtl/tms9918_color_to_rgb.sv
// Maps a TMS9918 colour index to 4-bit-per-channel RGB.
// Latency: combinational; the caller registers the result.
// Backpressure: none.
module tms9918_color_to_rgb
    import vga_output_stage_pkg::*;
(
    input  logic [3:0] color,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b
);

    logic [11:0] rgb;

    // Palette lookup split into channels.
    always_comb begin
        rgb = PALETTE[color];
        r   = rgb[11:8];
        g   = rgb[7:4];
        b   = rgb[3:0];
    end

endmodule

// File: rtl/vga_output_stage.sv
// Final VGA pixel stage: counter-based blanking, active-low syncs, registered RGB/DE, scanline dim.
// Latency: 1 clk_en tick from sync/colour inputs to every pin.
// Backpressure: none; clk_en=0 freezes all state and outputs.
module vga_output_stage
    import vga_output_stage_pkg::*;
#(
    parameter int COLOR_BITS   = 4,
    parameter int H_ACT_START  = 48,
    parameter int H_ACT_LEN    = 600,
    parameter int V_ACT_START  = 35,
    parameter int V_ACT_LEN    = 480,
    parameter bit SCANLINE_DIM = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  sync_h_in,
    input  logic                  sync_v_in,
    input  logic [3:0]            color_in,
    output logic                  vga_hs_n,
    output logic                  vga_vs_n,
    output logic [COLOR_BITS-1:0] vga_r,
    output logic [COLOR_BITS-1:0] vga_g,
    output logic [COLOR_BITS-1:0] vga_b,
    output logic                  vga_de
);

    // Palette channels are 4 bits; wider pins get the nibble replicated, narrower keep the MSBs.
    localparam int REP = (COLOR_BITS + 3) / 4;

    logic              sync_h_prev_q, sync_h_prev_d;
    logic              sync_v_prev_q, sync_v_prev_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [VCNT_W-1:0] vcnt_q, vcnt_d;
    logic              h_rise, v_rise;

    logic                  hs_n_q, hs_n_d;
    logic                  vs_n_q, vs_n_d;
    logic                  de_q, de_d;
    logic [COLOR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    logic [3:0]            pal_r, pal_g, pal_b;
    logic [4*REP-1:0]      r_wide, g_wide, b_wide;
    logic [COLOR_BITS-1:0] r_pix, g_pix, b_pix;
    logic [31:0]           hcnt_ext, vcnt_ext;
    logic                  active, dim_line;

    assign h_rise = sync_h_in & ~sync_h_prev_q;
    assign v_rise = sync_v_in & ~sync_v_prev_q;

    // Edge history and saturating beam counters; vsync rise overrides the line increment.
    always_comb begin
        sync_h_prev_d = sync_h_prev_q;
        sync_v_prev_d = sync_v_prev_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        if (clk_en) begin
            sync_h_prev_d = sync_h_in;
            sync_v_prev_d = sync_v_in;
            if (h_rise) begin
                hcnt_d = '0;
            end else if (hcnt_q != HCNT_MAX) begin
                hcnt_d = hcnt_q + 1'b1;
            end
            if (v_rise) begin
                vcnt_d = '0;
            end else if (h_rise && (vcnt_q != VCNT_MAX)) begin
                vcnt_d = vcnt_q + 1'b1;
            end
        end
    end

    // Counter and sync-history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_h_prev_q <= 1'b0;
            sync_v_prev_q <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
        end else begin
            sync_h_prev_q <= sync_h_prev_d;
            sync_v_prev_q <= sync_v_prev_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
        end
    end

    tms9918_color_to_rgb u_color_to_rgb (
        .color (color_in),
        .r     (pal_r),
        .g     (pal_g),
        .b     (pal_b)
    );

    assign r_wide = {REP{pal_r}};
    assign g_wide = {REP{pal_g}};
    assign b_wide = {REP{pal_b}};
    assign r_pix  = r_wide[4*REP-1 -: COLOR_BITS];
    assign g_pix  = g_wide[4*REP-1 -: COLOR_BITS];
    assign b_pix  = b_wide[4*REP-1 -: COLOR_BITS];

    // Window test uses the counters as they stand this tick, before any sync-rise update.
    assign hcnt_ext = 32'(hcnt_q);
    assign vcnt_ext = 32'(vcnt_q);
    assign active   = (hcnt_ext >= H_ACT_START) && (hcnt_ext < H_ACT_START + H_ACT_LEN) &&
                      (vcnt_ext >= V_ACT_START) && (vcnt_ext < V_ACT_START + V_ACT_LEN);
    assign dim_line = SCANLINE_DIM & vcnt_q[0];

    // Next pin values: inverted syncs, blanked/dimmed colour, DE aligned with colour.
    always_comb begin
        hs_n_d = hs_n_q;
        vs_n_d = vs_n_q;
        de_d   = de_q;
        r_d    = r_q;
        g_d    = g_q;
        b_d    = b_q;
        if (clk_en) begin
            hs_n_d = ~sync_h_in;
            vs_n_d = ~sync_v_in;
            de_d   = active;
            r_d    = '0;
            g_d    = '0;
            b_d    = '0;
            if (active) begin
                r_d = dim_line ? (r_pix >> 1) : r_pix;
                g_d = dim_line ? (g_pix >> 1) : g_pix;
                b_d = dim_line ? (b_pix >> 1) : b_pix;
            end
        end
    end

    // Pin registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_n_q <= SYNC_PIN_IDLE;
            vs_n_q <= SYNC_PIN_IDLE;
            de_q   <= 1'b0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            hs_n_q <= hs_n_d;
            vs_n_q <= vs_n_d;
            de_q   <= de_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
        end
    end

    assign vga_hs_n = hs_n_q;
    assign vga_vs_n = vs_n_q;
    assign vga_de   = de_q;
    assign vga_r    = r_q;
    assign vga_g    = g_q;
    assign vga_b    = b_q;

endmodule

// File: tb/tb_vga_output_stage.sv
// Bench for vga_output_stage: plain and scanline-dimmed instances against a beam-position model.
// Latency: checks pins 1 clk_en tick after each input set.
// Backpressure: clk_en randomly withheld with junk inputs to confirm nothing moves.
module tb_vga_output_stage;

    logic       clk = 1'b0;
    logic       reset, clk_en, sync_h_in, sync_v_in;
    logic [3:0] color_in;

    logic       hs_n_a, vs_n_a, de_a;
    logic [3:0] r_a, g_a, b_a;
    logic       hs_n_b, vs_n_b, de_b;
    logic [3:0] r_b, g_b, b_b;

    always #5 clk = ~clk;

    vga_output_stage u_dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .sync_h_in(sync_h_in), .sync_v_in(sync_v_in), .color_in(color_in),
        .vga_hs_n(hs_n_a), .vga_vs_n(vs_n_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_de(de_a)
    );

    vga_output_stage #(.SCANLINE_DIM(1'b1)) u_dim (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .sync_h_in(sync_h_in), .sync_v_in(sync_v_in), .color_in(color_in),
        .vga_hs_n(hs_n_b), .vga_vs_n(vs_n_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_de(de_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference palette (0xRGB per index; 0 is transparent -> black).
    logic [11:0] pal [16] = '{
        12'h000, 12'h000, 12'h2C3, 12'h5D6, 12'h54F, 12'h76F, 12'hD54, 12'h4EF,
        12'hF54, 12'hF76, 12'hDC3, 12'hDD8, 12'h3B2, 12'hC5C, 12'hCCC, 12'hFFF
    };

    localparam logic [14:0] PINS_RST = 15'h6000;

    // Beam model: horizontal tick count and line count since the last sync rises.
    int          m_h, m_v;
    bit          m_ph, m_pv;
    logic [14:0] exp_a, exp_b;

    function automatic logic [11:0] halve(input logic [11:0] c);
        return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_ph = 0; m_pv = 0;
        exp_a = PINS_RST; exp_b = PINS_RST;
    endtask

    task automatic model_tick(input bit sh, input bit sv, input logic [3:0] col);
        bit          act;
        logic [11:0] px, pxd;
        act = (m_h >= 48) && (m_h < 648) && (m_v >= 35) && (m_v < 515);
        px  = act ? pal[col] : 12'h000;
        pxd = (m_v % 2 == 1) ? halve(px) : px;
        exp_a = {~sh, ~sv, act, px};
        exp_b = {~sh, ~sv, act, pxd};
        if (sv && !m_pv)      m_v = 0;
        else if (sh && !m_ph) m_v = (m_v + 1 > 1023) ? 1023 : m_v + 1;
        if (sh && !m_ph)      m_h = 0;
        else                  m_h = (m_h + 1 > 2047) ? 2047 : m_h + 1;
        m_ph = sh; m_pv = sv;
    endtask

    task automatic cyc(input bit en, input bit sh, input bit sv, input logic [3:0] col, input bit rst);
        clk_en = en; sync_h_in = sh; sync_v_in = sv; color_in = col; reset = rst;
        @(posedge clk);
        #1;
        if (rst)     model_reset();
        else if (en) model_tick(sh, sv, col);
        chk("pins", {17'd0, hs_n_a, vs_n_a, de_a, r_a, g_a, b_a}, {17'd0, exp_a});
        chk("pins_dim", {17'd0, hs_n_b, vs_n_b, de_b, r_b, g_b, b_b}, {17'd0, exp_b});
    endtask

    task automatic junk_cyc(input bit en, input bit rst);
        cyc(en, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rst);
    endtask

    // One enabled tick, preceded by a random number of frozen cycles with junk inputs.
    task automatic tick(input bit sh, input bit sv, input logic [3:0] col);
        while ($urandom_range(0, 7) == 0) junk_cyc(1'b0, 1'b0);
        cyc(1'b1, sh, sv, col, 1'b0);
    endtask

    // One line: hsync high for hs_w ticks at the start; col_mode < 0 means random colours.
    // lno is the expected line count since vsync, used for the directed boundary checks.
    task automatic line(input int len, input int hs_w, input bit vs, input int col_mode,
                        input bit directed, input int lno, output int de_cnt);
        logic [3:0] c;
        de_cnt = 0;
        for (int t = 0; t < len; t++) begin
            c = (col_mode < 0) ? 4'($urandom_range(0, 15)) : 4'(col_mode);
            tick(t < hs_w, vs, c);
            if (de_a) de_cnt++;
            if (directed) begin
                if (t == 48)  chk("h_open_pre", 32'(de_a), 32'd0);
                if (t == 49)  chk("h_open", 32'({de_a, r_a, g_a, b_a}), 32'h1FFF);
                if (t == 648) chk("h_close_last", 32'(de_a), 32'd1);
                if (t == 649) chk("h_close", 32'(de_a), 32'd0);
                if (t == 100) chk("scanline", 32'({r_b, g_b, b_b}), (lno % 2 == 1) ? 32'h777 : 32'hFFF);
            end
        end
    endtask

    int dc;

    initial begin
        reset = 1'b1; clk_en = 1'b1; sync_h_in = 1'b1; sync_v_in = 1'b1; color_in = 4'hF;
        model_reset();

        // Reset with enable high and arbitrary inputs.
        junk_cyc(1'b1, 1'b1);
        junk_cyc(1'b1, 1'b1);
        chk("reset_pins", 32'({hs_n_a, vs_n_a, de_a, r_a, g_a, b_a}), 32'(PINS_RST));

        // Frame start: vsync and hsync rise together on line 0.
        for (int l = 0; l < 37; l++) begin
            line(56, 6, l < 3, -1, 1'b0, l, dc);
            if (l == 34) chk("v_blank_34", 32'(dc), 32'd0);
            if (l == 35) chk("v_first_active", 32'(dc > 0), 32'd1);
        end

        // Full-width lines inside the vertical window.
        for (int l = 37; l < 41; l++) begin
            line(700, 60, 1'b0, 15, 1'b1, l, dc);
            if (l > 37) chk("de_per_line", 32'(dc), 32'd600);
        end

        // Mid-line freeze of 10 clocks with junk on every input.
        for (int t = 0; t < 20; t++) tick(t < 6, 1'b0, 4'($urandom_range(0, 15)));
        for (int k = 0; k < 10; k++) junk_cyc(1'b0, 1'b0);
        for (int t = 20; t < 56; t++) tick(1'b0, 1'b0, 4'($urandom_range(0, 15)));

        // Rest of the frame, across the bottom of the vertical window.
        for (int l = 42; l < 521; l++) begin
            line(56, 6, 1'b0, -1, 1'b0, l, dc);
            if (l == 514) chk("v_last_active", 32'(dc > 0), 32'd1);
            if (l == 516) chk("v_window_end", 32'(dc), 32'd0);
        end

        // Reset in the middle of a line.
        line(56, 6, 1'b1, -1, 1'b0, 0, dc);
        for (int t = 0; t < 30; t++) tick(t < 6, 1'b1, 4'($urandom_range(0, 15)));
        junk_cyc(1'b1, 1'b1);
        chk("reset_mid", 32'({hs_n_a, vs_n_a, de_a, r_a, g_a, b_a}), 32'(PINS_RST));

        // Missing hsync inside the vertical window: hcnt saturates, output stays blank.
        for (int l = 0; l < 41; l++) line(56, 6, l < 2, -1, 1'b0, l, dc);
        for (int t = 0; t < 2200; t++) tick(1'b0, 1'b0, 4'hF);
        chk("hsat_blank", 32'({de_a, r_a, g_a, b_a}), 32'd0);
        line(56, 6, 1'b0, 15, 1'b0, 41, dc);
        chk("h_recover", 32'(dc > 0), 32'd1);

        // Missing vsync: run past 1023 lines so vcnt saturates.
        for (int l = 0; l < 1030; l++) line(16, 4, 1'b0, -1, 1'b0, l, dc);
        line(56, 6, 1'b0, 15, 1'b0, 0, dc);
        chk("vsat_blank", 32'(dc), 32'd0);
        line(56, 6, 1'b1, 15, 1'b0, 0, dc);
        for (int l = 1; l < 37; l++) line(56, 6, 1'b0, 15, 1'b0, l, dc);
        chk("v_recover", 32'(dc > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
